rr_arbiter32: RTL and testbench

//  Round-robin arbiter granting one shared resource (e.g. PE array or memory port) to 32 requesters.
//  - One owner at a time. Grant offered by valid/ready, ownership released by a done pulse.
//  - A watchdog reclaims the resource if the owner never signals done.
//  - Winner selection uses a 32-bit leading-one (MSB-first) priority encoder.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/prio_enc32.sv | 27 ++
 rtl/rr_arbiter32.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter32.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 32-way round-robin arbiter.
// Holds the arbiter state type, the requester count and grant index width,
// and a small helper that turns a grant index into a one-hot owner vector.
package arb_pkg;

   localparam int N_REQ = 32;
   localparam int IDX_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2
   } arb_state_t;

   // Expands a grant index into the one-hot owner vector driven on the grant bus.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/prio_enc32.sv
// Combinational 32-bit leading-one (MSB-first) priority encoder.
// Ports:
//   in   [31:0]  request vector
//   idx  [4:0]   index of the highest set bit (0 when nothing is set)
//   vld          at least one bit of 'in' is set
module prio_enc32
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] in,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // Scanning upward and overwriting on every set bit leaves the highest
   // set bit as the result, which gives MSB-first priority.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (in[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign vld = |in;

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter handing one shared resource to 32 requesters.
// A winner is offered with gnt_vld_o until the resource accepts it with
// gnt_rdy_i; the owner then holds the resource until it pulses done_i or
// the watchdog reclaims it after TIMEOUT busy cycles (TIMEOUT=0 disables it).
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   req_i      [31:0] per-requester request level
//   gnt_rdy_i  resource accepts the offered grant this cycle
//   done_i     owner finished (only honoured while busy)
//   gnt_vld_o  grant offered
//   gnt_idx_o  [4:0] index of the granted/owning requester
//   gnt_o      [31:0] one-hot owner vector while offered or busy
//   busy_o     resource is owned
//   to_err_o   one-cycle pulse when the watchdog forces a release
module rr_arbiter32
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   input  logic             gnt_rdy_i,
   input  logic             done_i,
   output logic             gnt_vld_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic [N_REQ-1:0] gnt_o,
   output logic             busy_o,
   output logic             to_err_o
);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] last_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [TO_W-1:0]  wd_cnt;
   logic [TO_W-1:0]  wd_nxt;
   logic             to_err_nxt;
   logic             wd_hit;
   logic             rel;

   logic [N_REQ-1:0] low_req;
   logic [IDX_W-1:0] low_idx;
   logic [IDX_W-1:0] all_idx;
   logic             low_vld;
   logic             all_vld;
   logic [IDX_W-1:0] winner;

   // Requesters strictly below the last owner get first pick; if none of
   // them is asking, the search wraps to the top of the full request vector.
   // This yields descending round-robin order, and after reset (last_idx=0)
   // the mask is empty so the highest requester wins first.
   assign low_req = req_i & ((N_REQ'(1) << last_idx) - N_REQ'(1));

   prio_enc32 u_enc_low (
      .in  (low_req),
      .idx (low_idx),
      .vld (low_vld)
   );

   prio_enc32 u_enc_all (
      .in  (req_i),
      .idx (all_idx),
      .vld (all_vld)
   );

   assign winner = low_vld ? low_idx : all_idx;

   // The watchdog fires on the last allowed busy cycle; a constant-zero
   // TIMEOUT removes the check entirely.
   assign wd_hit = (TIMEOUT != 0) && (wd_cnt == TO_W'(TIMEOUT - 1));

   // Next-state logic. A grant, once offered, is held until accepted even if
   // its request drops. Leaving BUSY (done or watchdog) chains straight into
   // a new offer when anyone is waiting, so there is no idle bubble. done_i
   // takes precedence over the watchdog, suppressing the error pulse.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = gnt_idx_o;
      last_nxt   = last_idx;
      wd_nxt     = wd_cnt;
      to_err_nxt = 1'b0;
      rel        = 1'b0;
      case (state)
         IDLE: begin
            if (all_vld) begin
               idx_nxt   = winner;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (gnt_rdy_i) begin
               last_nxt  = gnt_idx_o;
               wd_nxt    = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            wd_nxt     = wd_cnt + 1'b1;
            rel        = done_i || wd_hit;
            to_err_nxt = wd_hit && !done_i;
            if (rel) begin
               if (all_vld) begin
                  idx_nxt   = winner;
                  state_nxt = GRANT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, round-robin pointer, watchdog and registered outputs. The
   // outputs are computed from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_idx  <= '0;
         wd_cnt    <= '0;
         gnt_vld_o <= 1'b0;
         gnt_idx_o <= '0;
         gnt_o     <= '0;
         busy_o    <= 1'b0;
         to_err_o  <= 1'b0;
      end else begin
         state     <= state_nxt;
         last_idx  <= last_nxt;
         wd_cnt    <= wd_nxt;
         gnt_vld_o <= (state_nxt == GRANT);
         gnt_idx_o <= idx_nxt;
         gnt_o     <= (state_nxt != IDLE) ? idx_to_onehot(idx_nxt) : '0;
         busy_o    <= (state_nxt == BUSY);
         to_err_o  <= to_err_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter32.sv
// Self-checking bench for rr_arbiter32 built with an 8-cycle watchdog.
// A behavioural model tracks who owns the resource and picks winners by
// walking the requesters downward from the last owner with wraparound.
module tb_rr_arbiter32;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic [31:0] req_i;
   logic        gnt_rdy_i;
   logic        done_i;
   logic        gnt_vld_o;
   logic [4:0]  gnt_idx_o;
   logic [31:0] gnt_o;
   logic        busy_o;
   logic        to_err_o;

   int n_vec;
   int n_err;

   // Model: phase 0 = nobody holds anything, 1 = offered, 2 = owned.
   int m_phase;
   int m_idx;
   int m_last;
   int m_age;
   bit m_err;

   rr_arbiter32 #(
      .TIMEOUT (TMO),
      .TO_W    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .gnt_rdy_i (gnt_rdy_i),
      .done_i    (done_i),
      .gnt_vld_o (gnt_vld_o),
      .gnt_idx_o (gnt_idx_o),
      .gnt_o     (gnt_o),
      .busy_o    (busy_o),
      .to_err_o  (to_err_o)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Next requester after 'last' in descending order, wrapping 0 -> 31.
   function automatic int pick(input logic [31:0] r, input int last);
      int i;
      for (int k = 1; k <= 32; k++) begin
         i = (last - k + 64) % 32;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   // Advances the model by one clock using the inputs that were sampled.
   task automatic stepModel();
      m_err = 1'b0;
      if (rst) begin
         m_phase = 0;
         m_idx   = 0;
         m_last  = 0;
         m_age   = 0;
      end else if (m_phase == 0) begin
         if (req_i != 0) begin
            m_idx   = pick(req_i, m_last);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (gnt_rdy_i) begin
            m_last  = m_idx;
            m_age   = 0;
            m_phase = 2;
         end
      end else begin
         if (done_i || m_age == TMO - 1) begin
            m_err = !done_i;
            if (req_i != 0) begin
               m_idx   = pick(req_i, m_last);
               m_phase = 1;
            end else begin
               m_phase = 0;
            end
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compares every output against the model.
   task automatic checkOutput();
      logic [31:0] exp_gnt;
      exp_gnt = (m_phase != 0) ? (32'd1 << m_idx) : 32'd0;
      checkField("gnt_vld", 32'(gnt_vld_o), 32'(m_phase == 1));
      checkField("gnt_idx", 32'(gnt_idx_o), 32'(m_idx));
      checkField("gnt", gnt_o, exp_gnt);
      checkField("busy", 32'(busy_o), 32'(m_phase == 2));
      checkField("to_err", 32'(to_err_o), 32'(m_err));
   endtask

   // Drives one cycle of inputs, clocks it, updates the model and checks.
   task automatic applyStimulus(input logic r, input logic [31:0] rq, input logic rdy, input logic dn);
      @(negedge clk);
      rst       = r;
      req_i     = rq;
      gnt_rdy_i = rdy;
      done_i    = dn;
      @(posedge clk);
      stepModel();
      #1;
      checkOutput();
   endtask

   // Directed scenarios first, then a randomized run against the model.
   initial begin
      int rot_seq [4];
      rot_seq = '{31, 4, 0, 31};
      n_vec = 0;
      n_err = 0;
      m_phase = 0; m_idx = 0; m_last = 0; m_age = 0; m_err = 1'b0;
      rst = 1'b1; req_i = '0; gnt_rdy_i = 1'b0; done_i = 1'b0;

      // Reset, then a lone request from index 0.
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      checkField("rst_gnt", gnt_o, 32'h0);
      applyStimulus(1'b0, 32'h0000_0001, 1'b0, 1'b0);
      checkField("first_vld", 32'(gnt_vld_o), 32'd1);
      checkField("first_idx", 32'(gnt_idx_o), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      // Rotation with three requesters held.
      applyStimulus(1'b0, 32'h8000_0011, 1'b0, 1'b0);
      checkField("rot0", 32'(gnt_idx_o), 32'(rot_seq[0]));
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 32'h8000_0011, 1'b1, 1'b0);
         if (k < 3) begin
            applyStimulus(1'b0, 32'h8000_0011, 1'b0, 1'b1);
            checkField("rot", 32'(gnt_idx_o), 32'(rot_seq[k+1]));
         end
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      // Stalled ready with the request withdrawn.
      applyStimulus(1'b0, 32'h0000_0400, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkField("stall_idx", 32'(gnt_idx_o), 32'd10);
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkField("stall_busy", 32'(busy_o), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      // Back-to-back handover with no idle bubble.
      applyStimulus(1'b0, 32'h0000_8000, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0000_0300, 1'b0, 1'b1);
      checkField("b2b_vld", 32'(gnt_vld_o), 32'd1);
      checkField("b2b_idx", 32'(gnt_idx_o), 32'd9);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      // Watchdog expiry, then done on the last cycle instead.
      applyStimulus(1'b0, 32'h0010_0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int k = 1; k <= TMO; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkField("wd_err", 32'(to_err_o), 32'(k == TMO));
      end
      checkField("wd_busy", 32'(busy_o), 32'd0);
      applyStimulus(1'b0, 32'h0010_0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int k = 1; k <= TMO; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, k == TMO);
      end
      checkField("wd_done_err", 32'(to_err_o), 32'd0);

      // Reset in the middle of ownership.
      applyStimulus(1'b0, 32'h0000_0020, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      checkField("rst_busy", 32'(busy_o), 32'd0);
      applyStimulus(1'b0, 32'h8000_0001, 1'b0, 1'b0);
      checkField("rst_next", 32'(gnt_idx_o), 32'd31);

      // Randomized traffic, including stray done/ready and occasional reset.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] rq;
         rq = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 7) == 0) rq = '0;
         applyStimulus($urandom_range(0, 99) == 0, rq,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
